// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock, MSB first.
// A zero divisor skips the iteration phase and reports saturated results at once.
module seq_divider #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [CW-1:0] r_cnt;
    logic          r_fin;
    logic [n:0]    r_rem;
    logic [n-1:0]  r_quo;
    logic [n-1:0]  r_dvs;

    logic          w_accept;
    logic          w_dvs_zero;
    logic [n+1:0]  w_shift;
    logic [n+1:0]  w_trial;
    logic          w_fits;

    // A request is taken whenever no division is in flight.
    assign w_accept   = start && (r_state != RUN);
    assign w_dvs_zero = (divisor == '0);

    // Shifted partial remainder and trial subtraction; the extra top bit is the sign.
    assign w_shift = {r_rem, r_quo[n-1]};
    assign w_trial = w_shift - {2'b00, r_dvs};
    assign w_fits  = ~w_trial[n+1];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_next = w_dvs_zero ? DONE : RUN;
                end else if (r_state == DONE) begin
                    w_next = IDLE;
                end
            end
            RUN: begin
                if (r_fin) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
    end

    // Datapath: operand capture, iterations, and result registers loaded on entry to DONE.
    // RUN spends n cycles iterating, then one more cycle (r_fin set) publishing the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_fin       <= 1'b0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_quo <= dividend;
            r_dvs <= divisor;
            r_rem <= '0;
            r_cnt <= '0;
            r_fin <= 1'b0;
            if (w_dvs_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (r_state == RUN) begin
            if (!r_fin) begin
                r_rem <= w_fits ? w_trial[n:0] : w_shift[n:0];
                r_quo <= {r_quo[n-2:0], w_fits};
                if (r_cnt == CW'(n - 1)) begin
                    r_fin <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                quotient    <= r_quo;
                remainder   <= r_rem[n-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver predicts each accepted request with
// plain / and % and its done cycle; a monitor checks every done pulse and busy.
module tb_seq_divider;

    localparam int N = 16;

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    seq_divider #(.n(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         z;
        int           due;
    } exp_t;

    exp_t sb[$];

    int cyc      = 0;
    int free_at  = 0;
    int busy_lo  = 1;
    int busy_hi  = 0;
    int accepted = 0;
    int checks   = 0;
    int errors   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    // Drive one cycle of inputs and predict whether the coming edge accepts them.
    task automatic step(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
        int   k;
        exp_t e;
        @(negedge clk);
        start    = s;
        dividend = a;
        divisor  = b;
        k = cyc + 1;
        if (s && !reset && k >= free_at) begin
            if (b == 0) begin
                e.q = '1;
                e.r = a;
                e.z = 1'b1;
                e.due = k;
                free_at = k + 1;
            end else begin
                e.q = a / b;
                e.r = a % b;
                e.z = 1'b0;
                e.due = k + N + 1;
                free_at = k + N + 2;
                busy_lo = k;
                busy_hi = k + N;
            end
            sb.push_back(e);
            accepted++;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 60) begin
            step(1'b0, N'($urandom), N'($urandom));
            t++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compare every done pulse with the oldest prediction; check busy each cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
        chk("busy", {31'd0, busy}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d: got done=1 expected 0", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.due);
                chk("quotient", {16'd0, quotient}, {16'd0, e.q});
                chk("remainder", {16'd0, remainder}, {16'd0, e.r});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_done at cycle %0d: got done=0 expected 1", cyc);
            void'(sb.pop_front());
        end
    end

    initial begin
        logic         s;
        logic [N-1:0] a;
        logic [N-1:0] b;
        int           sel;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_quotient", {16'd0, quotient}, 32'd0);
        chk("reset_remainder", {16'd0, remainder}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        #1 reset = 1'b0;

        // First start right after reset release, then the basic cases.
        step(1'b1, 16'd100, 16'd7);
        step(1'b0, '0, '0);
        wait_drain();
        step(1'b1, 16'hFFFF, 16'd1);
        step(1'b0, '0, '0);
        wait_drain();
        step(1'b1, 16'd3, 16'd10);
        step(1'b0, '0, '0);
        wait_drain();
        step(1'b1, 16'd5, 16'd0);
        step(1'b0, '0, '0);
        wait_drain();

        // A second start during RUN must be ignored.
        step(1'b1, 16'd100, 16'd7);
        repeat (4) step(1'b0, 16'd1, 16'd1);
        step(1'b1, 16'd9, 16'd3);
        step(1'b0, '0, '0);
        wait_drain();

        // Asynchronous reset mid-run aborts; a fresh request afterwards completes.
        step(1'b1, 16'd100, 16'd7);
        repeat (9) step(1'b0, '0, '0);
        #2 reset = 1'b1;
        #1;
        chk("async_quotient", {16'd0, quotient}, 32'd0);
        chk("async_remainder", {16'd0, remainder}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_done", {31'd0, done}, 32'd0);
        chk("async_dbz", {31'd0, div_by_zero}, 32'd0);
        sb.delete();
        busy_lo = 1;
        busy_hi = 0;
        free_at = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        step(1'b1, 16'd50, 16'd5);
        step(1'b0, '0, '0);
        wait_drain();

        // Random regression: start mostly held high, operands change every cycle.
        accepted = 0;
        for (int i = 0; i < 60000; i++) begin
            if (accepted >= 2000) break;
            s   = ($urandom_range(7) != 0);
            a   = N'($urandom);
            sel = $urandom_range(9);
            if (sel == 0)      b = '0;
            else if (sel < 4)  b = N'($urandom_range(15, 1));
            else               b = N'($urandom);
            step(s, a, b);
        end
        step(1'b0, '0, '0);
        wait_drain();
        step(1'b0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
